rf_access_ctrl: RTL
===================

Name: rf_access_ctrl

Overview:
Initiator side of the register-file interface in the multicycle MIPS CPU.
- Accepts one instruction word from the control unit.
- Decodes the register fields and drives the rs/rt read addresses.
- Latches the read data into operand registers A and B.
- Waits for the ALU/memory result, then issues exactly one write to the register file.
- Owns destination selection (rd, rt or $31) and enforces the $0 write guard on the initiator side.

Parameters:
LINK_REG, 31, destination register number for jal.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  synchronous reset, active-high.
instr  in  32  instruction word; sampled on the instr_valid&&instr_ready edge.
instr_valid  in  1  instruction offered.
instr_ready  out  1  high in IDLE and WRITE.
rf_rs  out  5  register-file read address 1.
rf_rt  out  5  register-file read address 2.
rf_rdata1  in  32  register-file read data 1; combinational from rf_rs.
rf_rdata2  in  32  register-file read data 2; combinational from rf_rt.
rf_rd  out  5  register-file write address.
rf_wdata  out  32  register-file write data.
rf_we  out  1  register-file write enable.
opnd_a  out  32  latched operand A.
opnd_b  out  32  latched operand B.
opnd_valid  out  1  one-cycle pulse: opnd_a/opnd_b newly valid.
wb_data  in  32  result to write back.
wb_valid  in  1  result offered.
wb_ready  out  1  high only in WAIT_WB.

Behaviour:
- Reset: state=IDLE; rf_we=0, opnd_valid=0; rf_rs, rf_rt, rf_rd=0; rf_wdata, opnd_a, opnd_b=0; instr_ready=1, wb_ready=0. Reset asserted in any state drops the pending write; rf_we must be 0 in the following cycle.
- States:
  - IDLE: on accept (cycle T), register instr; rf_rs=instr[25:21], rf_rt=instr[20:16] valid from T+1; compute dest; go to LATCH.
  - LATCH (T+1): opnd_a<=rf_rdata1, opnd_b<=rf_rdata2. opnd_valid=1 during T+2 only. Next state is WAIT_WB if has_wb, else IDLE.
  - WAIT_WB: on wb_valid, either go to WRITE (dest!=0) or go to IDLE (dest==0; result consumed, no write).
  - WRITE: rf_we=1 for exactly one cycle, then IDLE. An instruction may be accepted in WRITE; if so the next state is LATCH instead of IDLE.
- Write-port timing: rf_rd and rf_wdata load on the same edge that enters WRITE and hold until the next WRITE entry. rf_we is high only in WRITE.
- Dest decode (opcode = instr[31:26]):
  - 000000 with funct != 001000 → rd = instr[15:11].
  - 000000 with funct == 001000 (jr) → no write.
  - 100011, 001000, 001001, 001100, 001101, 001010, 001111 → rt.
  - 000011 → LINK_REG.
  - All other opcodes (sw, beq, bne, j, …) → has_wb=0.
- Ignored inputs: wb_valid outside WAIT_WB is ignored. instr_valid while instr_ready=0 is ignored; the producer holds it.
- rf_we is never asserted with rf_rd==0.

Optional Feature:
RF_WB_FORWARD_EN
- Defined: in a LATCH that directly follows WRITE, if rf_rs (resp. rf_rt) equals the just-written rf_rd and is nonzero, opnd_a (resp. opnd_b) takes rf_wdata instead of rf_rdata1/2. This covers register files with delayed write visibility.
- Undefined: operands always come from rf_rdata1/2.

Decomposition:
- Package rf_pkg holds:
  - state encoding (IDLE, LATCH, WAIT_WB, WRITE);
  - opcode and funct constants;
  - REG_ZERO=0.
- One natural sub-module, rf_dest_decode: combinational; instr → {has_wb, dest[4:0]}.

Test Plan:
1. Hold rst high 2 cycles, then release → rf_we=0, opnd_valid=0, instr_ready=1, wb_ready=0.
2. RF $1=5, $2=7; accept 0x00221820 (add $3,$1,$2) at T → rf_rs=1, rf_rt=2 at T+1; opnd_a=5, opnd_b=7, opnd_valid=1 at T+2; then wb_data=12 with wb_valid → one cycle rf_we=1, rf_rd=3, rf_wdata=12.
3. Accept 0x8D280004 (lw $8,4($9)), then wb_data=0xDEADBEEF → rf_rd=8, single rf_we pulse. Accept 0x0C000010 (jal) → rf_rd=31.
4. Accept 0xAD280004 (sw) → opnd_valid at T+2, back in IDLE, wb_ready never high; a wb_valid pulse afterwards → no rf_we.
5. Accept 0x20200001 (addi $0,$1,1), then wb_valid → result consumed, rf_we stays 0. Separately, assert rst in WAIT_WB then wb_valid → no rf_we.
6. Under RF_WB_FORWARD_EN: add $3 completes (wdata=12); accept 0x00631020 (add $2,$3,$3) during WRITE while the RF model delays visibility → opnd_a=opnd_b=12.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file access controller.
//   - FSM state encoding (IDLE, LATCH, WAIT_WB, WRITE)
//   - MIPS opcode / funct constants used by the destination decoder
//   - REG_ZERO, the hard-wired zero register number
//   - is_rt_dest_op(): helper that says whether an opcode writes rt
package rf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCH   = 2'd1,
    ST_WAIT_WB = 2'd2,
    ST_WRITE   = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // I-type opcodes whose result lands in the rt field.
  function automatic logic is_rt_dest_op(input logic [5:0] op);
    logic hit;
    case (op)
      OP_LW, OP_ADDI, OP_ADDIU, OP_ANDI,
      OP_ORI, OP_SLTI, OP_LUI:          hit = 1'b1;
      default:                          hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/rf_dest_decode.sv
// rf_dest_decode: combinational destination decoder.
// Turns an instruction word into {has_wb, dest}: whether the instruction
// produces a register result and which register receives it (rd, rt or
// LINK_REG). dest may legally be REG_ZERO; the controller drops such writes.
// Ports:
//   instr  [31:0] in   instruction word
//   has_wb        out  instruction produces a write-back
//   dest   [4:0]  out  destination register (REG_ZERO when has_wb=0)
module rf_dest_decode
  import rf_pkg::*;
#(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic [31:0] instr,
  output logic        has_wb,
  output logic [4:0]  dest
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign rt            = instr[20:16];
  assign rd            = instr[15:11];
  // rs and shamt never influence the destination.
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  // Destination selection from opcode/funct.
  always_comb begin
    has_wb = 1'b0;
    dest   = REG_ZERO;
    if (opcode == OP_RTYPE) begin
      if (funct == FUNCT_JR) begin
        has_wb = 1'b0;
        dest   = REG_ZERO;
      end else begin
        has_wb = 1'b1;
        dest   = rd;
      end
    end else if (is_rt_dest_op(opcode)) begin
      has_wb = 1'b1;
      dest   = rt;
    end else if (opcode == OP_JAL) begin
      has_wb = 1'b1;
      dest   = LINK_REG;
    end else begin
      // stores, branches, j and unknown opcodes: nothing to write
      has_wb = 1'b0;
      dest   = REG_ZERO;
    end
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: initiator side of the register-file interface of the
// multicycle MIPS CPU. Accepts an instruction, drives rs/rt read addresses,
// latches operands A/B, waits for the result and issues exactly one write
// (never to $0).
// Optional feature macro: RF_WB_FORWARD_EN -- when defined, a LATCH that
// directly follows WRITE takes the just-written data for a matching nonzero
// source register (register files with delayed write visibility).
// Ports:
//   clk, rst (sync, active-high)
//   instr[31:0], instr_valid, instr_ready    instruction handshake
//   rf_rs[4:0], rf_rt[4:0]                   read addresses
//   rf_rdata1[31:0], rf_rdata2[31:0]         read data (combinational)
//   rf_rd[4:0], rf_wdata[31:0], rf_we        write port
//   opnd_a[31:0], opnd_b[31:0], opnd_valid   latched operands + pulse
//   wb_data[31:0], wb_valid, wb_ready        result handshake
module rf_access_ctrl
  import rf_pkg::*;
#(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  rf_rs,
  output logic [4:0]  rf_rt,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        rf_we,
  output logic [31:0] opnd_a,
  output logic [31:0] opnd_b,
  output logic        opnd_valid,
  input  logic [31:0] wb_data,
  input  logic        wb_valid,
  output logic        wb_ready
);

  state_t      state;
  logic        pend_has_wb;
  logic [4:0]  pend_dest;
  logic        dec_has_wb;
  logic [4:0]  dec_dest;
  logic        accept;
  logic [31:0] next_a;
  logic [31:0] next_b;
`ifdef RF_WB_FORWARD_EN
  logic        after_write;
`endif

  rf_dest_decode #(
    .LINK_REG (LINK_REG)
  ) u_dest_decode (
    .instr  (instr),
    .has_wb (dec_has_wb),
    .dest   (dec_dest)
  );

  // instr_ready is a register that is high exactly in IDLE and WRITE.
  assign accept = instr_valid & instr_ready;

  // Operand source selection for the LATCH cycle.
  always_comb begin
    next_a = rf_rdata1;
    next_b = rf_rdata2;
`ifdef RF_WB_FORWARD_EN
    // rf_rd/rf_wdata still describe the write that just retired.
    if (after_write && (rf_rs == rf_rd) && (rf_rs != REG_ZERO)) begin
      next_a = rf_wdata;
    end else begin
      next_a = rf_rdata1;
    end
    if (after_write && (rf_rt == rf_rd) && (rf_rt != REG_ZERO)) begin
      next_b = rf_wdata;
    end else begin
      next_b = rf_rdata2;
    end
`endif
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      instr_ready <= 1'b1;
      wb_ready    <= 1'b0;
      rf_we       <= 1'b0;
      opnd_valid  <= 1'b0;
      rf_rs       <= REG_ZERO;
      rf_rt       <= REG_ZERO;
      rf_rd       <= REG_ZERO;
      rf_wdata    <= 32'd0;
      opnd_a      <= 32'd0;
      opnd_b      <= 32'd0;
      pend_has_wb <= 1'b0;
      pend_dest   <= REG_ZERO;
`ifdef RF_WB_FORWARD_EN
      after_write <= 1'b0;
`endif
    end else begin
      rf_we      <= 1'b0;
      opnd_valid <= 1'b0;

      // Capture the decoded instruction on every accept (IDLE or WRITE).
      if (accept) begin
        rf_rs       <= instr[25:21];
        rf_rt       <= instr[20:16];
        pend_has_wb <= dec_has_wb;
        pend_dest   <= dec_dest;
`ifdef RF_WB_FORWARD_EN
        after_write <= (state == ST_WRITE);
`endif
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_LATCH;
            instr_ready <= 1'b0;
          end
        end

        ST_LATCH: begin
          opnd_a     <= next_a;
          opnd_b     <= next_b;
          opnd_valid <= 1'b1;
          if (pend_has_wb) begin
            state    <= ST_WAIT_WB;
            wb_ready <= 1'b1;
          end else begin
            state       <= ST_IDLE;
            instr_ready <= 1'b1;
          end
        end

        ST_WAIT_WB: begin
          if (wb_valid) begin
            wb_ready    <= 1'b0;
            instr_ready <= 1'b1;
            // $0 guard: result is consumed but never written.
            if (pend_dest != REG_ZERO) begin
              state    <= ST_WRITE;
              rf_we    <= 1'b1;
              rf_rd    <= pend_dest;
              rf_wdata <= wb_data;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        ST_WRITE: begin
          if (accept) begin
            state       <= ST_LATCH;
            instr_ready <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state       <= ST_IDLE;
          instr_ready <= 1'b1;
          wb_ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule
